// File: rtl/fp_mult_pipe_if.sv
// Operand/result bundle for the pipelined single-precision multiplier.
`timescale 1ns/1ps
interface fp_mult_pipe_if;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  rnd;
  logic [31:0] z;
  logic [7:0]  status;

  modport master (output a, output b, output rnd, input z, input status);
  modport slave  (input a, input b, input rnd, output z, output status);
endinterface

// File: rtl/fp_mult_pipe.sv
// Two-stage IEEE-754 single multiplier: operand register, then multiply/round
// into z/status. Denormals flush to zero, NaN operands behave as infinity.
`timescale 1ns/1ps
module fp_mult_pipe (
  input  logic          clk,
  input  logic          rst,
  fp_mult_pipe_if.slave bus
);
  localparam logic [2:0] RND_NEAR = 3'b000;
  localparam logic [2:0] RND_ZERO = 3'b001;
  localparam logic [2:0] RND_PINF = 3'b010;
  localparam logic [2:0] RND_NINF = 3'b011;
  localparam logic [2:0] RND_UP   = 3'b100;
  localparam logic [2:0] RND_AWAY = 3'b101;

  function automatic logic round_up(input logic [2:0] mode, input logic sgn,
                                    input logic grd, input logic stk, input logic lsb);
    logic inx;
    inx = grd | stk;
    case (mode)
      RND_ZERO: round_up = 1'b0;
      RND_PINF: round_up = inx & ~sgn;
      RND_NINF: round_up = inx & sgn;
      RND_UP:   round_up = grd & (stk | ~sgn);
      RND_AWAY: round_up = inx;
      RND_NEAR: round_up = grd & (stk | lsb);
      default:  round_up = grd & (stk | lsb);
    endcase
  endfunction

  function automatic logic ovf_to_inf(input logic [2:0] mode, input logic sgn);
    case (mode)
      RND_ZERO: ovf_to_inf = 1'b0;
      RND_PINF: ovf_to_inf = ~sgn;
      RND_NINF: ovf_to_inf = sgn;
      default:  ovf_to_inf = 1'b1;
    endcase
  endfunction

  function automatic logic unf_to_zero(input logic [2:0] mode, input logic sgn);
    case (mode)
      RND_AWAY: unf_to_zero = 1'b0;
      RND_PINF: unf_to_zero = sgn;
      RND_NINF: unf_to_zero = ~sgn;
      default:  unf_to_zero = 1'b1;
    endcase
  endfunction

  logic [31:0] a_p1_d, a_p1_q, b_p1_d, b_p1_q;
  logic [2:0]  rnd_p1_d, rnd_p1_q;
  logic        vld_p1_d, vld_p1_q;
  logic [31:0] z_p2_d, z_p2_q;
  logic [7:0]  status_p2_d, status_p2_q;

  logic               sgn, a_zero, a_inf, b_zero, b_inf;
  logic [47:0]        prod;
  logic signed [9:0]  exp_sum, exp_norm, exp_rnd;
  logic [22:0]        mant_norm;
  logic [23:0]        mant_inc;
  logic               grd, stk, inx, inc, ovf, unf;

  // Stage 1: operand capture
  always_comb begin
    a_p1_d   = bus.a;
    b_p1_d   = bus.b;
    rnd_p1_d = bus.rnd;
    vld_p1_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_p1_q   <= '0;
      b_p1_q   <= '0;
      rnd_p1_q <= '0;
      vld_p1_q <= 1'b0;
    end else begin
      a_p1_q   <= a_p1_d;
      b_p1_q   <= b_p1_d;
      rnd_p1_q <= rnd_p1_d;
      vld_p1_q <= vld_p1_d;
    end
  end

  // Stage 2: multiply, normalise, round, classify
  always_comb begin
    sgn    = a_p1_q[31] ^ b_p1_q[31];
    a_zero = (a_p1_q[30:23] == 8'h00);
    a_inf  = (a_p1_q[30:23] == 8'hFF);
    b_zero = (b_p1_q[30:23] == 8'h00);
    b_inf  = (b_p1_q[30:23] == 8'hFF);

    prod    = {24'd0, 1'b1, a_p1_q[22:0]} * {24'd0, 1'b1, b_p1_q[22:0]};
    exp_sum = $signed({2'b00, a_p1_q[30:23]}) + $signed({2'b00, b_p1_q[30:23]}) - 10'sd127;

    if (prod[47]) begin
      exp_norm  = exp_sum + 10'sd1;
      mant_norm = prod[46:24];
      grd       = prod[23];
      stk       = |prod[22:0];
    end else begin
      exp_norm  = exp_sum;
      mant_norm = prod[45:23];
      grd       = prod[22];
      stk       = |prod[21:0];
    end

    inx      = grd | stk;
    inc      = round_up(rnd_p1_q, sgn, grd, stk, mant_norm[0]);
    mant_inc = {1'b0, mant_norm} + {23'd0, inc};
    // A carry out leaves mant_inc[22:0] at zero, so only the exponent moves.
    exp_rnd  = mant_inc[23] ? exp_norm + 10'sd1 : exp_norm;
    ovf      = (exp_rnd >= 10'sd255);
    unf      = (exp_rnd <= 10'sd0);

    z_p2_d      = 32'd0;
    status_p2_d = 8'd0;
    if (!vld_p1_q) begin
      z_p2_d      = 32'd0;
      status_p2_d = 8'd0;
    end else if ((a_zero & b_inf) | (a_inf & b_zero)) begin
      z_p2_d      = 32'h7FC0_0000;
      status_p2_d = 8'h04;
    end else if (a_zero | b_zero) begin
      z_p2_d      = {sgn, 31'd0};
      status_p2_d = 8'h01;
    end else if (a_inf | b_inf) begin
      z_p2_d      = {sgn, 8'hFF, 23'd0};
      status_p2_d = 8'h02;
    end else if (ovf) begin
      if (ovf_to_inf(rnd_p1_q, sgn)) begin
        z_p2_d      = {sgn, 8'hFF, 23'd0};
        status_p2_d = 8'h32;
      end else begin
        z_p2_d      = {sgn, 8'hFE, 23'h7F_FFFF};
        status_p2_d = 8'h30;
      end
    end else if (unf) begin
      if (unf_to_zero(rnd_p1_q, sgn)) begin
        z_p2_d      = {sgn, 31'd0};
        status_p2_d = 8'h29;
      end else begin
        z_p2_d      = {sgn, 8'h01, 23'd0};
        status_p2_d = 8'h28;
      end
    end else begin
      z_p2_d      = {sgn, exp_rnd[7:0], mant_inc[22:0]};
      status_p2_d = {2'b00, inx, 5'b00000};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      z_p2_q      <= '0;
      status_p2_q <= '0;
    end else begin
      z_p2_q      <= z_p2_d;
      status_p2_q <= status_p2_d;
    end
  end

  assign bus.z      = z_p2_q;
  assign bus.status = status_p2_q;
endmodule

// File: tb/tb_fp_mult_pipe.sv
// Bench for fp_mult_pipe: directed vector table, random ops against an
// integer-arithmetic reference, latency/reset sequences and per-cycle invariants.
`timescale 1ns/1ps
module tb_fp_mult_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  fp_mult_pipe_if bus();
  fp_mult_pipe dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rnd;
    logic [31:0] z;
    logic [7:0]  st;
    string       name;
    bit          chk;
  } vec_t;

  vec_t tbl[28];
  vec_t pend[$];
  vec_t idle;

  function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic [2:0] rnd,
                              logic [31:0] z, logic [7:0] st, string name);
    vec_t v;
    v.a = a; v.b = b; v.rnd = rnd; v.z = z; v.st = st; v.name = name; v.chk = 1'b1;
    return v;
  endfunction

  // Reference: exact integer product, rounding decided by comparing the
  // discarded remainder against half an ulp.
  function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] rnd,
                                    output logic [31:0] z, output logic [7:0] st);
    int ea, eb, e, sh;
    logic s;
    logic [2:0] m;
    longint unsigned ma, mb, p, q, rem, half;
    bit up, ex, big;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    m  = (rnd > 3'd5) ? 3'd0 : rnd;
    if ((ea == 0 && eb == 255) || (ea == 255 && eb == 0)) begin
      z = 32'h7FC0_0000; st = 8'h04; return;
    end
    if (ea == 0 || eb == 0) begin z = {s, 31'd0}; st = 8'h01; return; end
    if (ea == 255 || eb == 255) begin z = {s, 8'hFF, 23'd0}; st = 8'h02; return; end
    ma = 64'h80_0000 | {41'd0, a[22:0]};
    mb = 64'h80_0000 | {41'd0, b[22:0]};
    p  = ma * mb;
    e  = ea + eb - 127;
    big = (p >= 64'h8000_0000_0000);
    sh = big ? 24 : 23;
    if (big) e = e + 1;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    ex   = (rem != 0);
    case (m)
      3'd0:    up = (rem > half) || (rem == half && q[0]);
      3'd1:    up = 1'b0;
      3'd2:    up = ex && !s;
      3'd3:    up = ex && s;
      3'd4:    up = (rem > half) || (rem == half && !s);
      default: up = ex;
    endcase
    if (up) q = q + 64'd1;
    if (q == 64'h100_0000) begin q = 64'h80_0000; e = e + 1; end
    if (e >= 255) begin
      if (m == 3'd1 || (m == 3'd2 && s) || (m == 3'd3 && !s)) begin
        z = {s, 8'hFE, 23'h7F_FFFF}; st = 8'h30;
      end else begin
        z = {s, 8'hFF, 23'd0}; st = 8'h32;
      end
    end else if (e <= 0) begin
      if (m == 3'd5 || (m == 3'd2 && !s) || (m == 3'd3 && s)) begin
        z = {s, 8'h01, 23'd0}; st = 8'h28;
      end else begin
        z = {s, 31'd0}; st = 8'h29;
      end
    end else begin
      z  = {s, 8'(e), q[22:0]};
      st = ex ? 8'h20 : 8'h00;
    end
  endfunction

  task automatic check(string name, logic [31:0] z_act, logic [7:0] st_act,
                       logic [31:0] z_exp, logic [7:0] st_exp);
    checks++;
    if (z_act !== z_exp || st_act !== st_exp) begin
      failures++;
      $display("FAIL %s: got z=%08h status=%02h, want z=%08h status=%02h",
               name, z_act, st_act, z_exp, st_exp);
    end
  endtask

  // One op per falling edge; the op issued two falls earlier is now on z/status.
  task automatic issue(vec_t v);
    vec_t e;
    @(negedge clk);
    if (pend.size() == 2) begin
      e = pend.pop_front();
      if (e.chk) check(e.name, bus.z, bus.status, e.z, e.st);
    end
    bus.a = v.a; bus.b = v.b; bus.rnd = v.rnd;
    pend.push_back(v);
  endtask

  task automatic drain();
    vec_t e;
    repeat (2) begin
      @(negedge clk);
      if (pend.size() != 0) begin
        e = pend.pop_front();
        if (e.chk) check(e.name, bus.z, bus.status, e.z, e.st);
      end
    end
    pend.delete();
  endtask

  function automatic logic [31:0] rand_op();
    logic [7:0] ex;
    int sel;
    sel = int'($urandom_range(0, 9));
    case (sel)
      0:       ex = 8'h00;
      1:       ex = 8'hFF;
      2:       ex = 8'($urandom_range(1, 20));
      3:       ex = 8'($urandom_range(230, 254));
      default: ex = 8'($urandom_range(64, 190));
    endcase
    return {1'($urandom_range(0, 1)), ex, 23'($urandom)};
  endfunction

  // Status/encoding invariants on every cycle out of reset.
  logic [31:0] ha1 = 0, ha2 = 0, hb1 = 0, hb2 = 0;
  always @(posedge clk) begin
    ha2 <= ha1; ha1 <= bus.a;
    hb2 <= hb1; hb1 <= bus.b;
  end

  always @(negedge clk) begin
    if (rst) begin
      bit ok;
      ok = 1'b1;
      if (bus.status[0] && bus.z[30:23] != 8'h00) ok = 1'b0;
      if (bus.status[1] && bus.z[30:23] != 8'hFF) ok = 1'b0;
      if (bus.status[4] && !(bus.z[30:0] == 31'h7F80_0000 || bus.z[30:0] == 31'h7F7F_FFFF)) ok = 1'b0;
      if (bus.status[3] && !(bus.z[30:0] == 31'h0 || bus.z[30:0] == 31'h0080_0000)) ok = 1'b0;
      if (bus.status[2] && !((ha2[30:23] == 8'h00 && hb2[30:23] == 8'hFF) ||
                             (ha2[30:23] == 8'hFF && hb2[30:23] == 8'h00))) ok = 1'b0;
      if ((int'(bus.status[0]) + int'(bus.status[1]) + int'(bus.status[2])) > 1) ok = 1'b0;
      if (bus.status[7:6] != 2'b00) ok = 1'b0;
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL invariant at %0t: z=%08h status=%02h", $time, bus.z, bus.status);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rz;
    logic [7:0]  rs;
    vec_t v;

    idle = mk(32'h3F80_0000, 32'h3F80_0000, 3'd0, 32'h3F80_0000, 8'h00, "idle");
    idle.chk = 1'b0;
    tbl[0]  = mk(32'h4000_0000, 32'h4040_0000, 3'd0, 32'h40C0_0000, 8'h00, "two_x_three");
    tbl[1]  = mk(32'h3F80_0000, 32'h3F80_0000, 3'd0, 32'h3F80_0000, 8'h00, "one_x_one");
    tbl[2]  = mk(32'hC000_0000, 32'h4040_0000, 3'd0, 32'hC0C0_0000, 8'h00, "neg_two_x_three");
    tbl[3]  = mk(32'h0000_0000, 32'h3F80_0000, 3'd0, 32'h0000_0000, 8'h01, "pos_zero");
    tbl[4]  = mk(32'h8000_0000, 32'h3F80_0000, 3'd0, 32'h8000_0000, 8'h01, "neg_zero");
    tbl[5]  = mk(32'h0000_0001, 32'h3F80_0000, 3'd0, 32'h0000_0000, 8'h01, "denormal_flush");
    tbl[6]  = mk(32'h7F80_0000, 32'hBF80_0000, 3'd0, 32'hFF80_0000, 8'h02, "inf_x_norm");
    tbl[7]  = mk(32'h0000_0000, 32'h7F80_0000, 3'd0, 32'h7FC0_0000, 8'h04, "zero_x_inf");
    tbl[8]  = mk(32'h7F80_0000, 32'h0000_0000, 3'd0, 32'h7FC0_0000, 8'h04, "inf_x_zero");
    tbl[9]  = mk(32'h7FC0_0000, 32'h4000_0000, 3'd0, 32'h7F80_0000, 8'h02, "nan_as_inf");
    tbl[10] = mk(32'h7F00_0000, 32'h7F00_0000, 3'd0, 32'h7F80_0000, 8'h32, "ovf_near");
    tbl[11] = mk(32'h7F00_0000, 32'h7F00_0000, 3'd1, 32'h7F7F_FFFF, 8'h30, "ovf_zero");
    tbl[12] = mk(32'hFF00_0000, 32'h7F00_0000, 3'd3, 32'hFF80_0000, 8'h32, "ovf_ninf_neg");
    tbl[13] = mk(32'hFF00_0000, 32'h7F00_0000, 3'd2, 32'hFF7F_FFFF, 8'h30, "ovf_pinf_neg");
    tbl[14] = mk(32'h0080_0000, 32'h0080_0000, 3'd0, 32'h0000_0000, 8'h29, "unf_near");
    tbl[15] = mk(32'h0080_0000, 32'h0080_0000, 3'd5, 32'h0080_0000, 8'h28, "unf_away");
    tbl[16] = mk(32'h8080_0000, 32'h0080_0000, 3'd3, 32'h8080_0000, 8'h28, "unf_ninf_neg");
    tbl[17] = mk(32'h3F80_0001, 32'h3F80_0001, 3'd0, 32'h3F80_0002, 8'h20, "inexact");
    tbl[18] = mk(32'h3FFF_FFFE, 32'h3F80_0001, 3'd0, 32'h4000_0000, 8'h20, "round_carry");
    tbl[19] = mk(32'h3FFF_FFFE, 32'h3F80_0001, 3'd1, 32'h3FFF_FFFF, 8'h20, "trunc_no_carry");
    tbl[20] = mk(32'h7F7F_FFFE, 32'h3F80_0001, 3'd0, 32'h7F80_0000, 8'h32, "carry_into_ovf");
    tbl[21] = mk(32'h7F7F_FFFE, 32'h3F80_0001, 3'd1, 32'h7F7F_FFFF, 8'h20, "max_no_ovf");
    tbl[22] = mk(32'h0080_0000, 32'h3F00_0000, 3'd0, 32'h0000_0000, 8'h29, "exp_zero_unf");
    tbl[23] = mk(32'h0080_0000, 32'h3F80_0000, 3'd0, 32'h0080_0000, 8'h00, "exp_one_ok");
    tbl[24] = mk(32'h3F80_0001, 32'h4040_0000, 3'd0, 32'h4040_0002, 8'h20, "tie_even");
    tbl[25] = mk(32'hBF80_0001, 32'h4040_0000, 3'd4, 32'hC040_0001, 8'h20, "tie_up_neg");
    tbl[26] = mk(32'h3F80_0001, 32'h4040_0000, 3'd4, 32'h4040_0002, 8'h20, "tie_up_pos");
    tbl[27] = mk(32'hBF80_0001, 32'h4040_0000, 3'd6, 32'hC040_0002, 8'h20, "mode6_as_near");

    bus.a = 32'h4000_0000; bus.b = 32'h4040_0000; bus.rnd = 3'd0;
    repeat (2) @(negedge clk);
    check("reset_state", bus.z, bus.status, 32'd0, 8'd0);
    rst = 1'b1;

    foreach (tbl[i]) issue(tbl[i]);
    drain();

    for (int i = 0; i < 400; i++) begin
      v.a = rand_op(); v.b = rand_op(); v.rnd = 3'($urandom_range(0, 7));
      ref_model(v.a, v.b, v.rnd, rz, rs);
      v.z = rz; v.st = rs; v.name = $sformatf("rand%0d", i); v.chk = 1'b1;
      issue(v);
    end
    drain();

    // Explicit two-edge latency around a single op.
    issue(idle); issue(idle); drain();
    @(negedge clk); bus.a = 32'h4000_0000; bus.b = 32'h4040_0000; bus.rnd = 3'd0;
    @(negedge clk); check("latency_1edge", bus.z, bus.status, 32'h3F80_0000, 8'h00);
    bus.a = 32'h3F80_0000; bus.b = 32'h3F80_0000;
    @(negedge clk); check("latency_2edge", bus.z, bus.status, 32'h40C0_0000, 8'h00);
    @(negedge clk); check("latency_after", bus.z, bus.status, 32'h3F80_0000, 8'h00);

    // Asynchronous reset one cycle after issuing an op.
    @(negedge clk); bus.a = 32'h4000_0000; bus.b = 32'h4040_0000;
    @(negedge clk); rst = 1'b0;
    #1 check("rst_async_clear", bus.z, bus.status, 32'd0, 8'd0);
    bus.a = 32'h3F80_0001; bus.b = 32'h3F80_0001;
    @(negedge clk); check("rst_held", bus.z, bus.status, 32'd0, 8'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.z !== 32'd0) begin
      failures++;
      $display("FAIL rst_no_stale: got z=%08h, want z=00000000", bus.z);
    end
    @(negedge clk); check("rst_first_result", bus.z, bus.status, 32'h3F80_0002, 8'h20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
